// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder.
// Loads two WIDTH-bit operands and a carry-in, then adds one bit per clock
// through a single full-adder cell, LSB first, with a carry flip-flop.
// {cout,sum} = a + b + cin, produced WIDTH clocks after the accepting edge.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 1), default 8
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request, sampled only in IDLE
//   a, b   operands, sampled on the accepting edge
//   cin    carry-in, sampled on the accepting edge
//   busy   high while in SHIFT and DONE
//   done   one-cycle pulse, result valid
//   sum    result, held until the next completion
//   cout   final carry, held with sum
//   ovf    two's-complement overflow, held with sum
//          (present only when SERIAL_ADDER_OVF_EN is defined)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa, sb, sr, sr_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;

  // Single full-adder cell plus the next value of the result shifter, so the
  // completion edge can publish the result including the bit computed on it.
  always_comb begin
    fa_s             = sa[0] ^ sb[0] ^ carry;
    fa_c             = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
    sr_next          = sr >> 1;
    sr_next[WIDTH-1] = fa_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sr    <= sr_next;
          carry <= fa_c;
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          if (cnt == LAST) begin
            sum   <= sr_next;
            cout  <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            // carry currently holds the carry into the MSB cell
            ovf   <= carry ^ fa_c;
`endif
            done  <= 1'b1;
            state <= DONE;
          end else begin
            // held on the last bit so the counter never wraps
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: directed vectors on a WIDTH=8 instance, plus
// random operand sweeps on WIDTH=1, 8 and 16 instances.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start1, start16;
  logic [7:0]  a8, b8;
  logic [0:0]  a1, b1;
  logic [15:0] a16, b16;
  logic        cin8, cin1, cin16;
  logic        busy8, busy1, busy16;
  logic        done8, done1, done16;
  logic [7:0]  sum8;
  logic [0:0]  sum1;
  logic [15:0] sum16;
  logic        cout8, cout1, cout16;
`ifdef SERIAL_ADDER_OVF_EN
  logic        ovf8, ovf1, ovf16;
`endif

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  serial_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Runs one add on the WIDTH=8 instance and reports what it observed.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                      output int lat, output logic [7:0] s, output logic c,
                      output logic o, output logic stable, output logic busy_acc,
                      output logic busy_post, output logic done_post);
    logic [7:0] s0;
    a8 = ta; b8 = tb_v; cin8 = tc; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    busy_acc = busy8;
    a8 = ~ta; b8 = 8'h5A; cin8 = ~tc;  // operands may change after accept
    s0 = sum8; stable = 1'b1; lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      tick;
      lat++;
      if (done8 !== 1'b1 && sum8 !== s0) stable = 1'b0;
    end
    s = sum8; c = cout8;
`ifdef SERIAL_ADDER_OVF_EN
    o = ovf8;
`else
    o = 1'b0;
`endif
    tick;
    busy_post = busy8; done_post = done8;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start8 = 1'b1; start1 = 1'b1; start16 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;
    repeat (3) tick;
    compared++; if (busy8 !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy8); end
    compared++; if (done8 !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b expected 0", done8); end
    compared++; if (sum8 !== 8'h00) begin mismatched++; $display("FAIL reset_sum: got %h expected 00", sum8); end
    compared++; if (cout8 !== 1'b0) begin mismatched++; $display("FAIL reset_cout: got %b expected 0", cout8); end
`ifdef SERIAL_ADDER_OVF_EN
    compared++; if (ovf8 !== 1'b0) begin mismatched++; $display("FAIL reset_ovf: got %b expected 0", ovf8); end
`endif
    start8 = 1'b0; start1 = 1'b0; start16 = 1'b0;
    rst = 1'b0;
    tick;
    compared++; if (busy8 !== 1'b0) begin mismatched++; $display("FAIL reset_no_accept: got busy %b expected 0", busy8); end
  endtask

  task automatic test_basic;
    int lat; logic [7:0] s; logic c, o, st, ba, bp, dp;
    run8(8'h35, 8'h4A, 1'b0, lat, s, c, o, st, ba, bp, dp);
    compared++; if (ba !== 1'b1) begin mismatched++; $display("FAIL basic_busy_rise: got %b expected 1", ba); end
    compared++; if (lat !== 8) begin mismatched++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    compared++; if (s !== 8'h7F) begin mismatched++; $display("FAIL basic_sum: got %h expected 7f", s); end
    compared++; if (c !== 1'b0) begin mismatched++; $display("FAIL basic_cout: got %b expected 0", c); end
    compared++; if (st !== 1'b1) begin mismatched++; $display("FAIL basic_sum_stable: got %b expected 1", st); end
    compared++; if (bp !== 1'b0) begin mismatched++; $display("FAIL basic_busy_fall: got %b expected 0", bp); end
    compared++; if (dp !== 1'b0) begin mismatched++; $display("FAIL basic_done_pulse: got %b expected 0", dp); end
  endtask

  task automatic test_carry;
    int lat; logic [7:0] s; logic c, o, st, ba, bp, dp;
    run8(8'hFF, 8'h01, 1'b1, lat, s, c, o, st, ba, bp, dp);
    compared++; if (s !== 8'h01) begin mismatched++; $display("FAIL carry_sum: got %h expected 01", s); end
    compared++; if (c !== 1'b1) begin mismatched++; $display("FAIL carry_cout: got %b expected 1", c); end
`ifdef SERIAL_ADDER_OVF_EN
    compared++; if (o !== 1'b0) begin mismatched++; $display("FAIL carry_ovf: got %b expected 0", o); end
`endif
    run8(8'h7F, 8'h01, 1'b0, lat, s, c, o, st, ba, bp, dp);
    compared++; if (s !== 8'h80) begin mismatched++; $display("FAIL ovf_sum: got %h expected 80", s); end
    compared++; if (c !== 1'b0) begin mismatched++; $display("FAIL ovf_cout: got %b expected 0", c); end
`ifdef SERIAL_ADDER_OVF_EN
    compared++; if (o !== 1'b1) begin mismatched++; $display("FAIL ovf_flag: got %b expected 1", o); end
`endif
  endtask

  task automatic test_ignore_start;
    int pulses = 0; logic [7:0] s = 8'h00; logic c = 1'b0;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    repeat (2) tick;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (done8 === 1'b1) begin pulses++; s = sum8; c = cout8; end
      tick;
    end
    compared++; if (pulses !== 1) begin mismatched++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
    compared++; if (s !== 8'h46) begin mismatched++; $display("FAIL ignore_sum: got %h expected 46", s); end
    compared++; if (c !== 1'b0) begin mismatched++; $display("FAIL ignore_cout: got %b expected 0", c); end
    compared++; if (busy8 !== 1'b0) begin mismatched++; $display("FAIL ignore_idle: got busy %b expected 0", busy8); end
  endtask

  task automatic test_back_to_back;
    int n = 0; int t[3]; logic [7:0] sv[3];
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    for (int k = 0; k < 60 && n < 3; k++) begin
      tick;
      if (done8 === 1'b1) begin t[n] = cyc; sv[n] = sum8; n++; end
    end
    start8 = 1'b0;
    compared++; if (n !== 3) begin mismatched++; $display("FAIL b2b_count: got %0d expected 3", n); end
    if (n == 3) begin
      compared++; if (t[1] - t[0] !== 10) begin mismatched++; $display("FAIL b2b_gap1: got %0d expected 10", t[1] - t[0]); end
      compared++; if (t[2] - t[1] !== 10) begin mismatched++; $display("FAIL b2b_gap2: got %0d expected 10", t[2] - t[1]); end
      for (int i = 0; i < 3; i++) begin
        compared++; if (sv[i] !== 8'h30) begin mismatched++; $display("FAIL b2b_sum%0d: got %h expected 30", i, sv[i]); end
      end
    end
    repeat (2) tick;
    compared++; if (busy8 !== 1'b0) begin mismatched++; $display("FAIL b2b_idle: got busy %b expected 0", busy8); end
  endtask

  task automatic test_reset_mid;
    int pulses = 0; int lat; logic [7:0] s; logic c, o, st, ba, bp, dp;
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    #1;
    compared++; if (busy8 !== 1'b0) begin mismatched++; $display("FAIL midrst_busy: got %b expected 0", busy8); end
    compared++; if (sum8 !== 8'h00) begin mismatched++; $display("FAIL midrst_sum: got %h expected 00", sum8); end
    compared++; if (cout8 !== 1'b0) begin mismatched++; $display("FAIL midrst_cout: got %b expected 0", cout8); end
    repeat (2) begin tick; if (done8 === 1'b1) pulses++; end
    rst = 1'b0;
    repeat (10) begin tick; if (done8 === 1'b1) pulses++; end
    compared++; if (pulses !== 0) begin mismatched++; $display("FAIL midrst_no_done: got %0d pulses expected 0", pulses); end
    run8(8'h0F, 8'h01, 1'b0, lat, s, c, o, st, ba, bp, dp);
    compared++; if (s !== 8'h10) begin mismatched++; $display("FAIL midrst_resume_sum: got %h expected 10", s); end
    compared++; if (lat !== 8) begin mismatched++; $display("FAIL midrst_resume_lat: got %0d expected 8", lat); end
  endtask

  task automatic test_random;
    logic [1:0]  e1;
    logic [8:0]  e8;
    logic [16:0] e16;
    int l1, l8, l16;
    logic [1:0]  r1;
    logic [8:0]  r8;
    logic [16:0] r16;
    for (int it = 0; it < 1000; it++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      e1 = 2'(a1) + 2'(b1) + 2'(cin1);
      e8 = 9'(a8) + 9'(b8) + 9'(cin8);
      e16 = 17'(a16) + 17'(b16) + 17'(cin16);
      start1 = 1'b1; start8 = 1'b1; start16 = 1'b1;
      tick;
      start1 = 1'b0; start8 = 1'b0; start16 = 1'b0;
      l1 = -1; l8 = -1; l16 = -1; r1 = '0; r8 = '0; r16 = '0;
      for (int k = 1; k <= 18; k++) begin
        tick;
        if (done1 === 1'b1 && l1 < 0) begin l1 = k; r1 = {cout1, sum1}; end
        if (done8 === 1'b1 && l8 < 0) begin l8 = k; r8 = {cout8, sum8}; end
        if (done16 === 1'b1 && l16 < 0) begin l16 = k; r16 = {cout16, sum16}; end
      end
      compared++; if (l1 !== 1) begin mismatched++; $display("FAIL rand_w1_lat it%0d: got %0d expected 1", it, l1); end
      compared++; if (r1 !== e1) begin mismatched++; $display("FAIL rand_w1_sum it%0d: got %h expected %h", it, r1, e1); end
      compared++; if (l8 !== 8) begin mismatched++; $display("FAIL rand_w8_lat it%0d: got %0d expected 8", it, l8); end
      compared++; if (r8 !== e8) begin mismatched++; $display("FAIL rand_w8_sum it%0d: got %h expected %h", it, r8, e8); end
      compared++; if (l16 !== 16) begin mismatched++; $display("FAIL rand_w16_lat it%0d: got %0d expected 16", it, l16); end
      compared++; if (r16 !== e16) begin mismatched++; $display("FAIL rand_w16_sum it%0d: got %h expected %h", it, r16, e16); end
`ifdef SERIAL_ADDER_OVF_EN
      compared++;
      if (ovf8 !== ((a8[7] == b8[7]) && (e8[7] != a8[7]))) begin
        mismatched++; $display("FAIL rand_w8_ovf it%0d: got %b", it, ovf8);
      end
`endif
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
